// File: rtl/stream_demux_1to4.sv
// stream_demux_1to4: routes whole valid/ready packets to one of four channels; select sampled on first beat.
// Latency: one cycle from input accept to the channel output register.
// Backpressure: input stalls only when the destination register is full and not draining; other channels drain freely.
module stream_demux_1to4 #(
  parameter int DW   = 8,
  parameter int CNTW = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DW-1:0]     in_data,
  input  logic [1:0]        in_sel,
  input  logic              in_last,
  output logic [3:0]        out_valid,
  input  logic [3:0]        out_ready,
  output logic [4*DW-1:0]   out_data,
  output logic [3:0]        out_last,
  output logic [4*CNTW-1:0] pkt_cnt,
  output logic              busy
);

  typedef enum logic {
    IDLE  = 1'b0,
    ROUTE = 1'b1
  } state_t;

  state_t              state_q, state_d;
  logic [1:0]          route_q, route_d;
  logic [3:0]          out_valid_q, out_valid_d;
  logic [4*DW-1:0]     out_data_q, out_data_d;
  logic [3:0]          out_last_q, out_last_d;
  logic [4*CNTW-1:0]   pkt_cnt_q, pkt_cnt_d;

  logic [1:0]          dest;
  logic                accept;

  // Destination, input handshake, FSM next state and per-channel register updates.
  always_comb begin
    state_d     = state_q;
    route_d     = route_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_last_d  = out_last_q;
    pkt_cnt_d   = pkt_cnt_q;

    // in_sel only matters on a packet's first beat; mid-packet the latched route wins.
    dest     = (state_q == IDLE) ? in_sel : route_q;
    in_ready = ~rst & (~out_valid_q[dest] | out_ready[dest]);
    accept   = in_valid & in_ready;

    if (accept) begin
      if (state_q == IDLE && !in_last) begin
        state_d = ROUTE;
        route_d = in_sel;
      end else if (state_q == ROUTE && in_last) begin
        state_d = IDLE;
      end
    end

    for (int i = 0; i < 4; i++) begin
      if (accept && dest == 2'(i)) begin
        // A load wins over a drain, so a draining register refills without a bubble.
        out_valid_d[i]            = 1'b1;
        out_data_d[i*DW +: DW]    = in_data;
        out_last_d[i]             = in_last;
        if (in_last) begin
          pkt_cnt_d[i*CNTW +: CNTW] = pkt_cnt_q[i*CNTW +: CNTW] + CNTW'(1);
        end
      end else if (out_ready[i]) begin
        out_valid_d[i] = 1'b0;
      end
    end
  end

  // State and channel registers with synchronous reset; reset drops any partial packet.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      route_q     <= 2'd0;
      out_valid_q <= 4'd0;
      out_data_q  <= '0;
      out_last_q  <= 4'd0;
      pkt_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      route_q     <= route_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_last_q  <= out_last_d;
      pkt_cnt_q   <= pkt_cnt_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_last  = out_last_q;
  assign pkt_cnt   = pkt_cnt_q;
  assign busy      = (state_q == ROUTE);

endmodule

// File: tb/tb_stream_demux_1to4.sv
// tb_stream_demux_1to4: directed self-checking bench for the 1-to-4 packet demux.
// Inputs change 1ns after the rising edge; outputs are checked there too, clear of the edge.
// Combinational in_ready is checked 1ns after new inputs are applied.
module tb_stream_demux_1to4;

  localparam int DW   = 8;
  localparam int CNTW = 8;

  logic              clk;
  logic              rst;
  logic              in_valid;
  logic              in_ready;
  logic [DW-1:0]     in_data;
  logic [1:0]        in_sel;
  logic              in_last;
  logic [3:0]        out_valid;
  logic [3:0]        out_ready;
  logic [4*DW-1:0]   out_data;
  logic [3:0]        out_last;
  logic [4*CNTW-1:0] pkt_cnt;
  logic              busy;

  int n_checks = 0;
  int n_errors = 0;

  stream_demux_1to4 #(.DW(DW), .CNTW(CNTW)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_sel    (in_sel),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last),
    .pkt_cnt   (pkt_cnt),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [1:0] sel, input logic [7:0] d, input logic last);
    in_valid = v;
    in_sel   = sel;
    in_data  = d;
    in_last  = last;
  endtask

  function automatic logic [7:0] ch_data(input int i);
    return out_data[i*DW +: DW];
  endfunction

  initial begin
    rst = 1'b1;
    out_ready = 4'hF;
    drive(1'b0, 2'd0, 8'h00, 1'b0);
    #1;
    chk("in_ready_in_reset", in_ready, 1'b0);
    step();
    step();
    rst = 1'b0;
    #1;
    chk("rst_out_valid", out_valid, 4'b0000);
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_pkt_cnt", pkt_cnt, 32'h0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_out_data", out_data, 32'h0);

    // Single-beat packets to each channel in turn, all consumers ready.
    for (int k = 0; k < 4; k++) begin
      drive(1'b1, 2'(k), 8'hA0 + 8'(k), 1'b1);
      step();
      chk("single_valid", out_valid, 64'(4'b0001 << k));
      chk("single_data", ch_data(k), 8'hA0 + 8'(k));
      chk("single_busy", busy, 1'b0);
    end
    drive(1'b0, 2'd0, 8'h00, 1'b0);
    step();
    chk("single_drained", out_valid, 4'b0000);
    chk("single_cnt", pkt_cnt, 32'h01010101);

    // Three-beat packet to channel 2; in_sel changes mid-packet and must be ignored.
    drive(1'b1, 2'd2, 8'h11, 1'b0);
    step();
    chk("p3_b1_valid", out_valid, 4'b0100);
    chk("p3_b1_data", ch_data(2), 8'h11);
    chk("p3_b1_last", out_last[2], 1'b0);
    chk("p3_b1_busy", busy, 1'b1);
    drive(1'b1, 2'd1, 8'h22, 1'b0);
    step();
    chk("p3_b2_valid", out_valid, 4'b0100);
    chk("p3_b2_data", ch_data(2), 8'h22);
    chk("p3_b2_busy", busy, 1'b1);
    drive(1'b1, 2'd1, 8'h33, 1'b1);
    step();
    chk("p3_b3_valid", out_valid, 4'b0100);
    chk("p3_b3_data", ch_data(2), 8'h33);
    chk("p3_b3_last", out_last[2], 1'b1);
    chk("p3_b3_busy", busy, 1'b0);
    chk("p3_cnt", pkt_cnt, 32'h01020101);
    drive(1'b0, 2'd0, 8'h00, 1'b0);
    step();

    // Backpressure on channel 1.
    out_ready = 4'b1101;
    drive(1'b1, 2'd1, 8'h55, 1'b0);
    #1;
    chk("bp_first_ready", in_ready, 1'b1);
    step();
    drive(1'b1, 2'd1, 8'h66, 1'b0);
    #1;
    chk("bp_stall_ready", in_ready, 1'b0);
    step();
    chk("bp_hold_data", ch_data(1), 8'h55);
    chk("bp_hold_valid", out_valid[1], 1'b1);
    step();
    chk("bp_hold_data2", ch_data(1), 8'h55);
    out_ready = 4'hF;
    #1;
    chk("bp_release_ready", in_ready, 1'b1);
    step();
    chk("bp_refill_valid", out_valid[1], 1'b1);
    chk("bp_refill_data", ch_data(1), 8'h66);
    drive(1'b1, 2'd1, 8'h77, 1'b1);
    step();
    chk("bp_last_data", ch_data(1), 8'h77);
    chk("bp_last_flag", out_last[1], 1'b1);
    chk("bp_last_valid", out_valid[1], 1'b1);
    drive(1'b0, 2'd0, 8'h00, 1'b0);
    step();
    chk("bp_drained", out_valid, 4'b0000);
    chk("bp_cnt", pkt_cnt, 32'h01020201);

    // Stalled channel 3 must not block traffic to channel 0.
    out_ready = 4'b0111;
    drive(1'b1, 2'd3, 8'hC3, 1'b1);
    step();
    drive(1'b1, 2'd0, 8'hD0, 1'b1);
    #1;
    chk("iso_ready", in_ready, 1'b1);
    step();
    chk("iso_ch0_data", ch_data(0), 8'hD0);
    chk("iso_valid", out_valid, 4'b1001);
    chk("iso_ch3_data", ch_data(3), 8'hC3);
    drive(1'b0, 2'd3, 8'h00, 1'b1);
    #1;
    chk("iso_ch3_blocked", in_ready, 1'b0);
    out_ready = 4'hF;
    step();
    chk("iso_cnt", pkt_cnt, 32'h02020202);

    // Reset mid-packet with channel 2 holding a beat.
    out_ready = 4'b1011;
    drive(1'b1, 2'd2, 8'hE2, 1'b0);
    step();
    chk("mid_busy", busy, 1'b1);
    chk("mid_valid", out_valid, 4'b0100);
    rst = 1'b1;
    drive(1'b0, 2'd0, 8'h00, 1'b0);
    step();
    rst = 1'b0;
    out_ready = 4'hF;
    chk("mid_rst_valid", out_valid, 4'b0000);
    chk("mid_rst_busy", busy, 1'b0);
    chk("mid_rst_cnt", pkt_cnt, 32'h0);
    // First beat after reset: in_sel must be honoured again.
    drive(1'b1, 2'd0, 8'hF0, 1'b1);
    step();
    chk("post_rst_valid", out_valid, 4'b0001);
    chk("post_rst_data", ch_data(0), 8'hF0);
    chk("post_rst_busy", busy, 1'b0);

    // Counter wrap on channel 1.
    drive(1'b1, 2'd1, 8'h5A, 1'b1);
    for (int k = 0; k < 255; k++) step();
    chk("wrap_255", pkt_cnt, 32'h0000FF01);
    step();
    chk("wrap_0", pkt_cnt, 32'h00000001);
    drive(1'b0, 2'd0, 8'h00, 1'b0);
    step();
    chk("wrap_drained", out_valid, 4'b0000);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/stream_demux_1to4.md
Name: stream_demux_1to4

Overview:
- Registered 1-to-4 demultiplexer: the routing counterpart of the team's 4:1 select logic.
- Accepts one valid/ready input stream of packets and steers each whole packet to one of four output channels, chosen by a 2-bit select sampled on the packet's first beat.
- Each output channel has a one-entry output register.
- Keeps a per-channel completed-packet counter.
- Sits between a single producer and four independent consumers.

Parameters:
- DW, 8, data width in bits.
- CNTW, 8, width of each per-channel packet counter.

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  input beat valid.
- in_ready  output  1  input beat accepted when in_valid & in_ready.
- in_data  input  DW  input beat payload.
- in_sel  input  2  destination channel; sampled only on the first beat of a packet.
- in_last  input  1  marks the final beat of a packet.
- out_valid  output  4  per-channel valid; bit i belongs to channel i.
- out_ready  input  4  per-channel ready.
- out_data  output  4*DW  channel i payload in bits [i*DW +: DW].
- out_last  output  4  per-channel last flag.
- pkt_cnt  output  4*CNTW  channel i count in bits [i*CNTW +: CNTW].
- busy  output  1  high while in the middle of a packet (state ROUTE).

Behaviour:
- Reset (rst=1 at a clk edge) sets:
  - state to IDLE and route_q to 0;
  - out_valid, out_last and busy to 0;
  - out_data to all zeros;
  - all pkt_cnt fields to 0.
- While rst=1, in_ready=0.
- Reset asserted mid-packet discards the packet and any buffered beats; the next beat after reset is treated as a first beat.
- FSM states:
  - IDLE: next accepted beat is a first beat.
  - ROUTE: packet in progress; route_q holds its destination.
- Destination d = in_sel in IDLE; d = route_q in ROUTE. in_sel is ignored in ROUTE.
- in_ready = ~rst & (~out_valid[d] | out_ready[d]).
  - This path is combinational: in_ready may depend on in_sel (in IDLE) and on out_ready in the same cycle.
  - Readiness of non-destination channels has no effect.
- Accept = in_valid & in_ready. On accept, channel d's register loads in_data and in_last, and out_valid[d]=1 from the next cycle. Latency is one cycle from accept to output.
- FSM transitions:
  - IDLE, accept, in_last=0 -> ROUTE; route_q <= in_sel.
  - IDLE, accept, in_last=1 -> stay IDLE (single-beat packet).
  - ROUTE, accept, in_last=1 -> IDLE.
  - Any other case -> no state change.
- Output channel i:
  - out_valid[i] clears when out_ready[i]=1 and there is no same-cycle load into i.
  - A simultaneous drain and load keeps out_valid[i]=1 and presents the new beat; there are no bubbles and no beat is lost.
  - While out_valid[i] & ~out_ready[i], out_data and out_last for i are held stable.
  - Channels not addressed are untouched.
- Counters: pkt_cnt[d] increments by 1 on accept of a beat with in_last=1. It wraps from 2^CNTW-1 to 0 and does not saturate. A counter changes only on a last-beat accept to its own channel.
- busy = (state == ROUTE).
- Backpressure: a full, non-draining destination stalls the input; other channels continue to drain independently.
- Ordering: beats within a packet arrive on the destination channel in input order, with no interleaving between packets.

Test Plan:
- Reset then idle, no stimulus:
  - Required: out_valid=0000, in_ready=1, all pkt_cnt=0, busy=0.
  - Assert rst mid-ROUTE with channel 2 holding a beat: next cycle out_valid=0000, busy=0, pkt_cnt[2] unchanged from 0.
- Single-beat packets with all out_ready=1:
  - Send in_sel=0..3 with in_data=0xA0..0xA3, in_last=1, one per cycle.
  - Required: each appears one cycle later on channel 0..3 respectively; each pkt_cnt=1; busy stays 0.
- Three-beat packet, in_sel=2 on beat 1 only:
  - in_sel changes to 1 on beats 2–3; data 0x11, 0x22, 0x33.
  - Required: all three beats on channel 2 only; busy=1 after beat 1 until the beat-3 accept; out_last[2]=1 only with 0x33; pkt_cnt[2]=1.
- Backpressure:
  - Hold out_ready[1]=0 while streaming to channel 1.
  - Required: after the first beat, in_ready=0 and out_data for channel 1 is held at 0x55.
  - Raise out_ready[1]: the drain and the next load occur in the same cycle with out_valid[1] staying 1; throughput is one beat per cycle.
- Stalled channel isolation:
  - Channel 3 is full with out_ready[3]=0; a new packet targets channel 0.
  - Required: in_ready=1 and channel 0 receives the beat; channel 3's data is unchanged.
- Counter wrap (CNTW=8):
  - Send 256 single-beat packets to channel 1.
  - Required: pkt_cnt[1] goes 255 -> 0; other counters stay 0.
